// File: rtl/mempool_tcdm_rob.sv
// Reorder buffer between a core TCDM port and the interconnect: tags requests
// with slot ids and hands out-of-order network responses back in issue order.
module mempool_tcdm_rob #(
    parameter int unsigned NumOutstanding = 8,
    parameter int unsigned MetaIdWidth    = 5,
    parameter int unsigned DataWidth      = 32,
    localparam int unsigned SlotWidth     = $clog2(NumOutstanding),
    localparam int unsigned StrbWidth     = DataWidth / 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    // core request
    input  logic [31:0]            core_qaddr_i,
    input  logic                   core_qwrite_i,
    input  logic [3:0]             core_qamo_i,
    input  logic [DataWidth-1:0]   core_qdata_i,
    input  logic [StrbWidth-1:0]   core_qstrb_i,
    input  logic [MetaIdWidth-1:0] core_qid_i,
    input  logic                   core_qvalid_i,
    output logic                   core_qready_o,
    // core response
    output logic [DataWidth-1:0]   core_pdata_o,
    output logic                   core_perror_o,
    output logic [MetaIdWidth-1:0] core_pid_o,
    output logic                   core_pvalid_o,
    input  logic                   core_pready_i,
    // network request
    output logic [31:0]            net_qaddr_o,
    output logic                   net_qwrite_o,
    output logic [3:0]             net_qamo_o,
    output logic [DataWidth-1:0]   net_qdata_o,
    output logic [StrbWidth-1:0]   net_qstrb_o,
    output logic [SlotWidth-1:0]   net_qid_o,
    output logic                   net_qvalid_o,
    input  logic                   net_qready_i,
    // network response
    input  logic [DataWidth-1:0]   net_pdata_i,
    input  logic                   net_perror_i,
    input  logic [SlotWidth-1:0]   net_pid_i,
    input  logic                   net_pvalid_i,
    output logic                   net_pready_o,
    // status
    output logic [SlotWidth:0]     outstanding_o,
    output logic                   full_o
);

    localparam logic [SlotWidth:0] FullCount = (SlotWidth + 1)'(NumOutstanding);

    logic [SlotWidth-1:0]      wr_ptr_reg;
    logic [SlotWidth-1:0]      rd_ptr_reg;
    logic [SlotWidth:0]        count_reg;
    logic [NumOutstanding-1:0] alloc_vec;
    logic [NumOutstanding-1:0] done_vec;

    logic [MetaIdWidth-1:0] id_mem    [NumOutstanding];
    logic [DataWidth-1:0]   data_mem  [NumOutstanding];
    logic                   error_mem [NumOutstanding];

    logic full;
    logic req_fire;
    logic rsp_accept;
    logic rsp_ready;
    logic pop_fire;

    // Fullness is judged on the registered count only, so a slot released this
    // cycle cannot be handed out again until the next one.
    assign full          = (count_reg == FullCount);
    assign net_qvalid_o  = core_qvalid_i && !full;
    assign core_qready_o = net_qready_i && !full;
    assign req_fire      = core_qvalid_i && net_qready_i && !full;

    assign net_qaddr_o  = core_qaddr_i;
    assign net_qwrite_o = core_qwrite_i;
    assign net_qamo_o   = core_qamo_i;
    assign net_qdata_o  = core_qdata_i;
    assign net_qstrb_o  = core_qstrb_i;
    assign net_qid_o    = wr_ptr_reg;
    assign net_pready_o = 1'b1;

    // Only a slot that is waiting for data may take a response; anything else is dropped.
    assign rsp_accept = net_pvalid_i && alloc_vec[net_pid_i] && !done_vec[net_pid_i];
    assign rsp_ready  = alloc_vec[rd_ptr_reg] && done_vec[rd_ptr_reg];
    assign pop_fire   = rsp_ready && core_pready_i;

    genvar gi;
    generate
        for (gi = 0; gi < NumOutstanding; gi++) begin : g_slot
            logic alloc_reg;
            logic done_reg;
            logic is_rd;
            logic is_wr;
            logic is_rsp;

            assign is_rd  = (rd_ptr_reg == SlotWidth'(gi));
            assign is_wr  = (wr_ptr_reg == SlotWidth'(gi));
            assign is_rsp = (net_pid_i == SlotWidth'(gi));

            // The read and write pointers never name the same slot while both
            // handshakes can fire, so the priority order only matters for clarity.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    alloc_reg <= 1'b0;
                    done_reg  <= 1'b0;
                end else if (pop_fire && is_rd) begin
                    alloc_reg <= 1'b0;
                    done_reg  <= 1'b0;
                end else if (req_fire && is_wr) begin
                    alloc_reg <= 1'b1;
                    done_reg  <= 1'b0;
                end else if (rsp_accept && is_rsp) begin
                    done_reg  <= 1'b1;
                end
            end

            assign alloc_vec[gi] = alloc_reg;
            assign done_vec[gi]  = done_reg;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (req_fire) begin
            id_mem[wr_ptr_reg] <= core_qid_i;
        end
        if (rsp_accept) begin
            data_mem[net_pid_i]  <= net_pdata_i;
            error_mem[net_pid_i] <= net_perror_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (req_fire) begin
                wr_ptr_reg <= wr_ptr_reg + SlotWidth'(1);
            end
            if (pop_fire) begin
                rd_ptr_reg <= rd_ptr_reg + SlotWidth'(1);
            end
            case ({req_fire, pop_fire})
                2'b10:   count_reg <= count_reg + (SlotWidth + 1)'(1);
                2'b01:   count_reg <= count_reg - (SlotWidth + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign core_pvalid_o = rsp_ready;
    assign core_pid_o    = id_mem[rd_ptr_reg];
    assign core_pdata_o  = data_mem[rd_ptr_reg];
    assign core_perror_o = error_mem[rd_ptr_reg];
    assign outstanding_o = count_reg;
    assign full_o        = full;

    // Stray or duplicate network responses indicate an interconnect bug upstream.
    always_ff @(posedge clk_i) begin
        if (!rst_i && net_pvalid_i) begin
            assert (alloc_vec[net_pid_i] && !done_vec[net_pid_i])
            else $warning("mempool_tcdm_rob: response to slot %0d dropped (not awaiting data)",
                          net_pid_i);
        end
    end

endmodule

// File: tb/tb_mempool_tcdm_rob.sv
// Bench for mempool_tcdm_rob: directed scenarios plus random traffic, all checked
// against an in-order transaction queue model.
module tb_mempool_tcdm_rob;

    localparam int N = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] core_qaddr_i;
    logic        core_qwrite_i;
    logic [3:0]  core_qamo_i;
    logic [31:0] core_qdata_i;
    logic [3:0]  core_qstrb_i;
    logic [4:0]  core_qid_i;
    logic        core_qvalid_i;
    logic        core_qready_o;
    logic [31:0] core_pdata_o;
    logic        core_perror_o;
    logic [4:0]  core_pid_o;
    logic        core_pvalid_o;
    logic        core_pready_i;
    logic [31:0] net_qaddr_o;
    logic        net_qwrite_o;
    logic [3:0]  net_qamo_o;
    logic [31:0] net_qdata_o;
    logic [3:0]  net_qstrb_o;
    logic [2:0]  net_qid_o;
    logic        net_qvalid_o;
    logic        net_qready_i;
    logic [31:0] net_pdata_i;
    logic        net_perror_i;
    logic [2:0]  net_pid_i;
    logic        net_pvalid_i;
    logic        net_pready_o;
    logic [3:0]  outstanding_o;
    logic        full_o;

    always #5 clk_i = ~clk_i;

    mempool_tcdm_rob dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .core_qaddr_i(core_qaddr_i), .core_qwrite_i(core_qwrite_i), .core_qamo_i(core_qamo_i),
        .core_qdata_i(core_qdata_i), .core_qstrb_i(core_qstrb_i), .core_qid_i(core_qid_i),
        .core_qvalid_i(core_qvalid_i), .core_qready_o(core_qready_o),
        .core_pdata_o(core_pdata_o), .core_perror_o(core_perror_o), .core_pid_o(core_pid_o),
        .core_pvalid_o(core_pvalid_o), .core_pready_i(core_pready_i),
        .net_qaddr_o(net_qaddr_o), .net_qwrite_o(net_qwrite_o), .net_qamo_o(net_qamo_o),
        .net_qdata_o(net_qdata_o), .net_qstrb_o(net_qstrb_o), .net_qid_o(net_qid_o),
        .net_qvalid_o(net_qvalid_o), .net_qready_i(net_qready_i),
        .net_pdata_i(net_pdata_i), .net_perror_i(net_perror_i), .net_pid_i(net_pid_i),
        .net_pvalid_i(net_pvalid_i), .net_pready_o(net_pready_o),
        .outstanding_o(outstanding_o), .full_o(full_o)
    );

    // One entry per issued transaction, oldest first; slot = issue index mod N.
    typedef struct {
        logic [4:0]  id;
        logic [31:0] data;
        logic        err;
        bit          resp;
    } txn_t;

    txn_t        q[$];
    int unsigned pop_cnt;
    int unsigned issue_cnt;
    int          errors = 0;
    int          checks = 0;
    logic [4:0]  pop_ids[$];
    logic [31:0] pop_data[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, check every visible output against the model,
    // then advance the model by the handshakes the model says took place.
    task automatic cycle(input bit qv, input logic [4:0] qid, input bit nqr, input bit npv,
                         input logic [2:0] pid, input logic [31:0] pdata, input bit perr,
                         input bit cpr);
        bit exp_full, exp_pv, qfire, pfire;
        int idx;
        core_qvalid_i = qv;
        core_qid_i    = qid;
        core_qaddr_i  = $urandom;
        core_qwrite_i = 1'($urandom);
        core_qamo_i   = 4'($urandom);
        core_qdata_i  = $urandom;
        core_qstrb_i  = 4'($urandom);
        net_qready_i  = nqr;
        net_pvalid_i  = npv;
        net_pid_i     = pid;
        net_pdata_i   = pdata;
        net_perror_i  = perr;
        core_pready_i = cpr;
        #3;
        exp_full = (q.size() == N);
        exp_pv   = (q.size() > 0) && q[0].resp;
        chk("core_qready", 64'(core_qready_o), 64'(nqr && !exp_full));
        chk("net_qvalid", 64'(net_qvalid_o), 64'(qv && !exp_full));
        chk("outstanding", 64'(outstanding_o), 64'(q.size()));
        chk("full", 64'(full_o), 64'(exp_full));
        chk("net_pready", 64'(net_pready_o), 64'(1));
        chk("core_pvalid", 64'(core_pvalid_o), 64'(exp_pv));
        if (qv && !exp_full) begin
            chk("net_qid", 64'(net_qid_o), 64'(issue_cnt % N));
            chk("net_qpayload", {net_qaddr_o, net_qdata_o},  {core_qaddr_i, core_qdata_i});
            chk("net_qctrl", 64'({net_qwrite_o, net_qamo_o, net_qstrb_o}),
                64'({core_qwrite_i, core_qamo_i, core_qstrb_i}));
        end
        if (exp_pv) begin
            chk("core_pid", 64'(core_pid_o), 64'(q[0].id));
            chk("core_pdata", 64'(core_pdata_o), 64'(q[0].data));
            chk("core_perror", 64'(core_perror_o), 64'(q[0].err));
        end
        qfire = qv && nqr && !exp_full;
        pfire = exp_pv && cpr;
        if (pfire) begin
            pop_ids.push_back(core_pid_o);
            pop_data.push_back(core_pdata_o);
            $display("rsp #%0d id=%0d data=%08h err=%0d", pop_cnt, core_pid_o, core_pdata_o,
                     core_perror_o);
        end
        @(posedge clk_i);
        #1;
        if (npv) begin
            idx = (int'(pid) + N - int'(pop_cnt % N)) % N;
            if (idx < q.size() && !q[idx].resp) begin
                q[idx].data = pdata;
                q[idx].err  = perr;
                q[idx].resp = 1'b1;
            end
        end
        if (pfire) begin
            void'(q.pop_front());
            pop_cnt++;
        end
        if (qfire) begin
            q.push_back('{qid, 32'h0, 1'b0, 1'b0});
            issue_cnt++;
        end
    endtask

    task automatic issue(input logic [4:0] qid, input bit cpr);
        cycle(1'b1, qid, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0, cpr);
    endtask

    task automatic respond(input logic [2:0] pid, input logic [31:0] d, input bit cpr);
        cycle(1'b0, 5'd0, 1'b1, 1'b1, pid, d, 1'b0, cpr);
    endtask

    task automatic idle(input bit cpr);
        cycle(1'b0, 5'd0, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0, cpr);
    endtask

    task automatic do_reset();
        rst_i         = 1'b1;
        core_qvalid_i = 1'b0;
        net_pvalid_i  = 1'b0;
        core_pready_i = 1'b0;
        net_qready_i  = 1'b1;
        #3;
        chk("rst_pvalid", 64'(core_pvalid_o), 64'(0));
        chk("rst_full", 64'(full_o), 64'(0));
        chk("rst_outstanding", 64'(outstanding_o), 64'(0));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        q.delete();
        pop_cnt   = 0;
        issue_cnt = 0;
    endtask

    task automatic rand_cycle();
        int cand[$];
        bit npv;
        logic [2:0] pid;
        npv = 1'b0;
        pid = 3'd0;
        for (int i = 0; i < q.size(); i++) begin
            if (!q[i].resp) cand.push_back(i);
        end
        if (cand.size() > 0 && $urandom_range(0, 99) < 50) begin
            npv = 1'b1;
            pid = 3'((pop_cnt + cand[$urandom_range(0, cand.size() - 1)]) % N);
        end else if (q.size() < N && $urandom_range(0, 99) < 3) begin
            npv = 1'b1;
            pid = 3'((pop_cnt + q.size()) % N);
        end
        cycle($urandom_range(0, 99) < 60, 5'($urandom), $urandom_range(0, 99) < 70, npv, pid,
              $urandom, 1'($urandom), $urandom_range(0, 99) < 60);
    endtask

    initial begin
        logic [31:0] held;
        #1;
        do_reset();

        // Out-of-order return is reordered to issue order.
        pop_ids.delete();
        pop_data.delete();
        issue(5'd3, 1'b1);
        issue(5'd7, 1'b1);
        issue(5'd9, 1'b1);
        respond(3'd2, 32'hAAAA_000A, 1'b1);
        respond(3'd0, 32'hBBBB_000B, 1'b1);
        respond(3'd1, 32'hCCCC_000C, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("order_count", 64'(pop_ids.size()), 64'(3));
        if (pop_ids.size() == 3) begin
            chk("order_id0", 64'(pop_ids[0]), 64'(3));
            chk("order_d0", 64'(pop_data[0]), 64'(32'hBBBB_000B));
            chk("order_id1", 64'(pop_ids[1]), 64'(7));
            chk("order_d1", 64'(pop_data[1]), 64'(32'hCCCC_000C));
            chk("order_id2", 64'(pop_ids[2]), 64'(9));
            chk("order_d2", 64'(pop_data[2]), 64'(32'hAAAA_000A));
        end

        // Fill to capacity; a release while full must not admit a request that cycle.
        do_reset();
        for (int i = 0; i < N; i++) issue(5'(i + 1), 1'b0);
        issue(5'd20, 1'b0);
        respond(3'd0, 32'h1234_5678, 1'b0);
        cycle(1'b1, 5'd21, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1);
        core_qvalid_i = 1'b0;
        #2;
        chk("full_relief_qready", 64'(core_qready_o), 64'(1));
        chk("full_relief_full", 64'(full_o), 64'(0));
        #2;

        // Single-cycle response latency and payload hold under backpressure.
        do_reset();
        issue(5'd17, 1'b0);
        respond(3'd0, 32'hDEAD_BEEF, 1'b0);
        held = core_pdata_o;
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            chk("stall_hold", 64'(core_pdata_o), 64'(held));
        end
        idle(1'b1);

        // Back-to-back issue and pop with pointer wrap.
        do_reset();
        for (int i = 0; i < 3; i++) issue(5'(i), 1'b0);
        for (int i = 0; i < 3; i++) respond(3'(i), $urandom, 1'b0);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 5'(k + 10), 1'b1, k > 0, 3'((issue_cnt - 1) % N), $urandom, 1'b0, 1'b1);
            chk("b2b_outstanding", 64'(outstanding_o), 64'(3));
        end

        // Reset with traffic in flight; late response is dropped.
        do_reset();
        for (int i = 0; i < 4; i++) issue(5'(i), 1'b0);
        do_reset();
        respond(3'd1, 32'h5555_5555, 1'b1);
        idle(1'b1);
        chk("stale_pvalid", 64'(core_pvalid_o), 64'(0));
        chk("stale_outstanding", 64'(outstanding_o), 64'(0));

        // Duplicate response to a completed slot leaves the stored data alone.
        do_reset();
        issue(5'd11, 1'b0);
        respond(3'd0, 32'h0000_1111, 1'b0);
        respond(3'd0, 32'h0000_2222, 1'b0);
        idle(1'b0);
        chk("dup_data", 64'(core_pdata_o), 64'(32'h0000_1111));
        idle(1'b1);

        // Random traffic, then drain.
        do_reset();
        for (int i = 0; i < 800; i++) rand_cycle();
        for (int i = 0; i < 200 && q.size() > 0; i++) begin
            int cand_idx;
            cand_idx = -1;
            for (int j = 0; j < q.size(); j++) begin
                if (!q[j].resp && cand_idx < 0) cand_idx = j;
            end
            if (cand_idx >= 0)
                respond(3'((pop_cnt + cand_idx) % N), $urandom, 1'b1);
            else
                idle(1'b1);
        end
        chk("drain_empty", 64'(outstanding_o), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
